mac_out_fifo: RTL and testbench

// Output buffer directly downstream of the MAC array. Captures per-column psums from the

---
 rtl/mac_out_fifo.sv | 75 +++++++
 tb/tb_mac_out_fifo.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_out_fifo.sv
// Per-column output FIFOs behind the MAC array: each column has its own write pointer,
// and all columns share one read pointer, so every pop returns a whole de-skewed row.
module mac_out_fifo #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int depth   = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [psum_bw*col-1:0] in,
   input  logic [col-1:0]         wr,
   input  logic                   rd,
   output logic                   o_full,
   output logic                   o_ready,
   output logic                   o_valid,
   output logic [psum_bw*col-1:0] out,
   output logic                   overflow
);

   localparam int AW = $clog2(depth);

   logic [AW:0]              rptr;
   logic [col-1:0]           full_v;
   logic [col-1:0]           empty_v;
   logic [col-1:0]           wr_acc;
   logic [psum_bw*col-1:0]   rd_row;
   logic                     rd_acc;

   for (genvar c = 0; c < col; c++) begin : g_col
      logic [psum_bw-1:0] mem [depth];
      logic [AW:0]        wptr;

      assign empty_v[c] = (wptr == rptr);
      assign full_v[c]  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
      // Fullness is judged on pre-edge pointers, so a same-cycle read never frees room.
      assign wr_acc[c]  = wr[c] & ~full_v[c];
      assign rd_row[psum_bw*c +: psum_bw] = mem[rptr[AW-1:0]];

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            wptr <= '0;
         end else if (wr_acc[c]) begin
            wptr <= wptr + (AW+1)'(1);
         end
      end

      always_ff @(posedge clk) begin
         if (wr_acc[c]) begin
            mem[wptr[AW-1:0]] <= in[psum_bw*c +: psum_bw];
         end
      end
   end

   assign o_valid = &(~empty_v);
   assign o_full  = |full_v;
   assign o_ready = ~o_full;
   assign rd_acc  = rd & o_valid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rptr     <= '0;
         out      <= '0;
         overflow <= 1'b0;
      end else begin
         if (rd_acc) begin
            rptr <= rptr + (AW+1)'(1);
            out  <= rd_row;
         end
         if (|(wr & full_v)) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mac_out_fifo.sv
// Scoreboard bench for mac_out_fifo: per-column reference queues model the FIFOs and
// expected rows are queued when a read is issued, then compared once out updates.
module tb_mac_out_fifo;

   localparam int COL = 8;
   localparam int PBW = 16;
   localparam int DEP = 64;

   logic                 clk;
   logic                 reset;
   logic [PBW*COL-1:0]   in;
   logic [COL-1:0]       wr;
   logic                 rd;
   logic                 o_full;
   logic                 o_ready;
   logic                 o_valid;
   logic [PBW*COL-1:0]   out;
   logic                 overflow;

   int checks   = 0;
   int failures = 0;

   logic [PBW-1:0]     mq [COL][$];
   logic [PBW*COL-1:0] exp_q [$];
   logic               m_ovf;

   mac_out_fifo #(.col(COL), .psum_bw(PBW), .depth(DEP)) dut (
      .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd),
      .o_full(o_full), .o_ready(o_ready), .o_valid(o_valid),
      .out(out), .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   function automatic logic m_valid();
      logic v = 1'b1;
      for (int c = 0; c < COL; c++) if (mq[c].size() == 0) v = 1'b0;
      return v;
   endfunction

   function automatic logic m_full();
      logic f = 1'b0;
      for (int c = 0; c < COL; c++) if (mq[c].size() == DEP) f = 1'b1;
      return f;
   endfunction

   function automatic logic [PBW*COL-1:0] rand_row();
      logic [PBW*COL-1:0] r;
      for (int c = 0; c < COL; c++) r[c*PBW +: PBW] = PBW'($urandom);
      return r;
   endfunction

   task automatic model_clear();
      for (int c = 0; c < COL; c++) mq[c].delete();
      exp_q.delete();
      m_ovf = 1'b0;
   endtask

   // Drive one cycle, advance the reference model, and sample #1 after the edge.
   task automatic step(input logic [COL-1:0] w, input logic r, input logic [PBW*COL-1:0] d);
      logic [COL-1:0]     acc;
      logic [PBW*COL-1:0] row;
      wr = w; rd = r; in = d;
      for (int c = 0; c < COL; c++) begin
         acc[c] = w[c] && (mq[c].size() < DEP);
         if (w[c] && !acc[c]) m_ovf = 1'b1;
      end
      if (r && m_valid()) begin
         for (int c = 0; c < COL; c++) row[c*PBW +: PBW] = mq[c].pop_front();
         exp_q.push_back(row);
      end
      for (int c = 0; c < COL; c++) if (acc[c]) mq[c].push_back(d[c*PBW +: PBW]);
      @(posedge clk); #1;
      wr = '0; rd = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0; wr = '0; rd = 1'b0; in = '0;
      model_clear();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      model_clear();
      for (int i = 0; i < 3; i++) begin
         in = rand_row(); wr = COL'($urandom); rd = 1'($urandom);
         @(posedge clk); #1;
         checks++;
         if (out !== '0 || o_valid !== 1'b0 || o_full !== 1'b0 || o_ready !== 1'b1 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold out=%h valid=%b full=%b ready=%b ovf=%b required 0/0/0/1/0",
                     out, o_valid, o_full, o_ready, overflow);
         end
      end
      wr = '0; rd = 1'b0; in = '0;
      reset = 1'b1;
      step('0, 1'b0, '0);
      checks++;
      if (out !== '0 || o_valid !== 1'b0 || o_full !== 1'b0 || o_ready !== 1'b1 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL reset_release out=%h valid=%b full=%b ready=%b ovf=%b required 0/0/0/1/0",
                  out, o_valid, o_full, o_ready, overflow);
      end
   endtask

   task automatic test_skewed_fill();
      logic [PBW*COL-1:0] d, e;
      do_reset();
      for (int i = 0; i < COL; i++) begin
         for (int c = 0; c < COL; c++) d[c*PBW +: PBW] = PBW'(16'h0100 * c + i);
         step(COL'((1 << (i + 1)) - 1), 1'b0, d);
         checks++;
         if (o_valid !== (i == COL - 1)) begin
            failures++;
            $display("FAIL skew_valid step=%0d got=%b required=%b", i, o_valid, (i == COL - 1));
         end
      end
      step('0, 1'b1, '0);
      e = exp_q.pop_front();
      checks++;
      if (out !== e) begin
         failures++;
         $display("FAIL skew_row got=%h required=%h", out, e);
      end
      for (int c = 0; c < COL; c++) begin
         checks++;
         if (out[c*PBW +: PBW] !== PBW'(16'h0100 * c + c)) begin
            failures++;
            $display("FAIL skew_col%0d got=%h required=%h", c, out[c*PBW +: PBW], PBW'(16'h0100 * c + c));
         end
      end
   endtask

   task automatic test_full_overflow();
      logic [PBW*COL-1:0] e;
      do_reset();
      for (int k = 0; k <= DEP; k++) begin
         step(COL'(1), 1'b0, (PBW*COL)'(k));
         if (k == DEP - 1) begin
            checks++;
            if (o_full !== 1'b1 || o_ready !== 1'b0 || overflow !== 1'b0) begin
               failures++;
               $display("FAIL full_at_64 full=%b ready=%b ovf=%b required 1/0/0", o_full, o_ready, overflow);
            end
         end
      end
      checks++;
      if (overflow !== m_ovf || overflow !== 1'b1 || o_full !== 1'b1 || o_ready !== 1'b0) begin
         failures++;
         $display("FAIL overflow_65 ovf=%b full=%b ready=%b required 1/1/0", overflow, o_full, o_ready);
      end
      for (int k = 0; k < DEP; k++) step(8'hFE, 1'b0, rand_row());
      for (int k = 0; k < DEP; k++) begin
         step('0, 1'b1, '0);
         e = exp_q.pop_front();
         checks++;
         if (out !== e || out[PBW-1:0] !== PBW'(k)) begin
            failures++;
            $display("FAIL full_drain row=%0d got=%h required=%h", k, out, e);
         end
      end
      checks++;
      if (o_valid !== 1'b0 || o_full !== 1'b0 || overflow !== 1'b1) begin
         failures++;
         $display("FAIL full_after_drain valid=%b full=%b ovf=%b required 0/0/1", o_valid, o_full, overflow);
      end
   endtask

   task automatic test_read_not_valid();
      logic [PBW*COL-1:0] prev, e;
      do_reset();
      for (int k = 0; k < 3; k++) step(8'h7F, 1'b0, rand_row());
      checks++;
      if (o_valid !== 1'b0) begin
         failures++;
         $display("FAIL nv_valid got=%b required=0", o_valid);
      end
      prev = out;
      step('0, 1'b1, '0);
      checks++;
      if (out !== prev || o_valid !== 1'b0 || o_full !== 1'b0 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL nv_ignored out=%h valid=%b full=%b ovf=%b required %h/0/0/0", out, o_valid, o_full, overflow, prev);
      end
      step(8'h80, 1'b0, rand_row());
      checks++;
      if (o_valid !== 1'b1) begin
         failures++;
         $display("FAIL nv_valid_after got=%b required=1", o_valid);
      end
      step('0, 1'b1, '0);
      e = exp_q.pop_front();
      checks++;
      if (out !== e) begin
         failures++;
         $display("FAIL nv_first_row got=%h required=%h", out, e);
      end
   endtask

   task automatic test_back_to_back();
      logic [PBW*COL-1:0] e;
      int reads = 0;
      int full_seen = 0;
      do_reset();
      step(8'hFF, 1'b0, rand_row());
      for (int i = 1; i < 201; i++) begin
         if (i < 200) step(8'hFF, 1'b1, rand_row());
         else         step('0, 1'b1, '0);
         if (o_full !== 1'b0) full_seen++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            reads++;
            checks++;
            if (out !== e) begin
               failures++;
               $display("FAIL stream_row%0d got=%h required=%h", reads, out, e);
            end
         end
      end
      checks++;
      if (reads !== 200 || full_seen !== 0) begin
         failures++;
         $display("FAIL stream_summary reads=%0d full_cycles=%0d required 200/0", reads, full_seen);
      end
   endtask

   task automatic test_reset_midstream();
      logic [PBW*COL-1:0] e;
      do_reset();
      for (int k = 0; k < 10; k++) step(8'hFF, 1'b0, rand_row());
      step('0, 1'b1, '0);
      e = exp_q.pop_front();
      checks++;
      if (out !== e) begin
         failures++;
         $display("FAIL mid_pre_row got=%h required=%h", out, e);
      end
      #2 reset = 1'b0;
      model_clear();
      #1;
      checks++;
      if (out !== '0 || o_valid !== 1'b0 || o_full !== 1'b0 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL mid_async out=%h valid=%b full=%b ovf=%b required 0/0/0/0", out, o_valid, o_full, overflow);
      end
      @(posedge clk); #1 reset = 1'b1;
      for (int k = 0; k < 3; k++) step(8'hFF, 1'b0, rand_row());
      for (int k = 0; k < 3; k++) begin
         step('0, 1'b1, '0);
         e = exp_q.pop_front();
         checks++;
         if (out !== e) begin
            failures++;
            $display("FAIL mid_new_row%0d got=%h required=%h", k, out, e);
         end
      end
      checks++;
      if (o_valid !== 1'b0) begin
         failures++;
         $display("FAIL mid_empty_after valid=%b required=0", o_valid);
      end
   endtask

   initial begin
      reset = 1'b0; in = '0; wr = '0; rd = 1'b0; m_ovf = 1'b0;
      #3;
      test_reset();
      test_skewed_fill();
      test_full_overflow();
      test_read_not_valid();
      test_back_to_back();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
